// File: rtl/machine_timer_pkg.sv
// Shared definitions for the machine timer and its CSR-side consumers.
// Holds bus widths, the register map, the mtimecmp reset value, the MIP bit
// indices used by the CSR unit, and the decoded bus request payload.
package machine_timer_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TIME_W = 64;

  // Register map (byte offsets, word aligned)
  localparam logic [ADDR_W-1:0] MTIME_LO    = 5'h00;
  localparam logic [ADDR_W-1:0] MTIME_HI    = 5'h04;
  localparam logic [ADDR_W-1:0] MTIMECMP_LO = 5'h08;
  localparam logic [ADDR_W-1:0] MTIMECMP_HI = 5'h0C;
  localparam logic [ADDR_W-1:0] MSIP        = 5'h10;

  // Compare starts at the maximum so the timer IRQ stays quiet out of reset
  localparam logic [TIME_W-1:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // MIP bit positions for the two interrupt lines
  localparam int unsigned MIP_MSIP_BIT = 3;
  localparam int unsigned MIP_MTIP_BIT = 7;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/machine_timer_if.sv
// Data-bus interface of the machine timer.
//   master: drives read_request, write_request, address, write_data
//   slave : drives read_data, response (one-cycle acknowledge)
interface machine_timer_if;
  import machine_timer_pkg::*;

  logic              read_request;
  logic              write_request;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              response;

  modport master (
    output read_request, write_request, address, write_data,
    input  read_data, response
  );

  modport slave (
    input  read_request, write_request, address, write_data,
    output read_data, response
  );

endinterface

// File: rtl/machine_timer_prescaler.sv
// timer_prescaler: divides clk by PRESCALE to produce the mtime tick.
// Only compiled when MACHINE_TIMER_PRESCALER_EN is defined.
//   clk     in  system clock
//   reset   in  asynchronous active-low reset
//   restart in  restart the count (mtime was written this cycle)
//   tick    out high in the cycle where the count wraps back to 0
`ifdef MACHINE_TIMER_PRESCALER_EN
module timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;

  // Count 0..LAST; tick is pre-computed so it is high while count_q == LAST
  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (restart || (count_q == LAST)) begin
      count_d = '0;
    end
    tick_d = (count_d == LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      tick_q  <= (LAST == '0);
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule
`endif

// File: rtl/machine_timer.sv
// machine_timer: memory-mapped RISC-V mtime / mtimecmp / msip block.
//   clk                           in  system clock
//   reset                         in  asynchronous active-low reset
//   bus                           slave side of machine_timer_if
//   time_value                    out current mtime (for CSR TIME/TIMEH)
//   interruption_request_timer    out registered (mtime >= mtimecmp)
//   interruption_request_software out registered msip[0]
// Build option: MACHINE_TIMER_PRESCALER_EN inserts timer_prescaler so mtime
// advances once every PRESCALE clocks; otherwise mtime advances every clock.
module machine_timer
  import machine_timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic              clk,
  input  logic              reset,
  machine_timer_if.slave    bus,
  output logic [TIME_W-1:0] time_value,
  output logic              interruption_request_timer,
  output logic              interruption_request_software
);

  if ((PRESCALE < 1) || (PRESCALE > 65535)) begin : g_prescale_range
    $error("machine_timer: PRESCALE must be in 1..65535");
  end

  bus_req_t          req_c;
  logic              wr_mtime_c;
  logic              tick;

  logic [TIME_W-1:0] mtime_q, mtime_d;
  logic [TIME_W-1:0] mtimecmp_q, mtimecmp_d;
  logic              msip_q, msip_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              response_q, response_d;
  logic              irq_timer_q, irq_timer_d;
  logic              irq_sw_q, irq_sw_d;

  assign req_c.rd    = bus.read_request;
  assign req_c.wr    = bus.write_request;
  assign req_c.addr  = bus.address;
  assign req_c.wdata = bus.write_data;

  // A write to either mtime half suppresses the increment and restarts the prescaler
  assign wr_mtime_c = req_c.wr && ((req_c.addr == MTIME_LO) || (req_c.addr == MTIME_HI));

`ifdef MACHINE_TIMER_PRESCALER_EN
  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .restart (wr_mtime_c),
    .tick    (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // Register file, bus decode and compare; reads see pre-write/pre-tick state
  always_comb begin
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    msip_d      = msip_q;
    read_data_d = '0;
    response_d  = req_c.rd || req_c.wr;
    irq_timer_d = (mtime_q >= mtimecmp_q);
    irq_sw_d    = msip_q;

    if (!wr_mtime_c && tick) begin
      mtime_d = mtime_q + TIME_W'(1);
    end

    if (req_c.rd) begin
      case (req_c.addr)
        MTIME_LO:    read_data_d = mtime_q[31:0];
        MTIME_HI:    read_data_d = mtime_q[63:32];
        MTIMECMP_LO: read_data_d = mtimecmp_q[31:0];
        MTIMECMP_HI: read_data_d = mtimecmp_q[63:32];
        MSIP:        read_data_d = DATA_W'(msip_q);
        default:     read_data_d = '0;
      endcase
    end

    if (req_c.wr) begin
      case (req_c.addr)
        MTIME_LO:    mtime_d[31:0]     = req_c.wdata;
        MTIME_HI:    mtime_d[63:32]    = req_c.wdata;
        MTIMECMP_LO: mtimecmp_d[31:0]  = req_c.wdata;
        MTIMECMP_HI: mtimecmp_d[63:32] = req_c.wdata;
        MSIP:        msip_d            = req_c.wdata[0];
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime_q     <= '0;
      mtimecmp_q  <= MTIMECMP_RESET;
      msip_q      <= 1'b0;
      read_data_q <= '0;
      response_q  <= 1'b0;
      irq_timer_q <= 1'b0;
      irq_sw_q    <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      read_data_q <= read_data_d;
      response_q  <= response_d;
      irq_timer_q <= irq_timer_d;
      irq_sw_q    <= irq_sw_d;
    end
  end

  assign bus.read_data                 = read_data_q;
  assign bus.response                  = response_q;
  assign time_value                    = mtime_q;
  assign interruption_request_timer    = irq_timer_q;
  assign interruption_request_software = irq_sw_q;

endmodule
